remote_comm: RTL and testbench
==============================

Name: remote_comm

Overview:
- Bench-side command transmitter / response receiver for the Knight's Tour robot.
- Serializes a 16-bit command over UART, high byte first, to the robot's RX pin.
- Receives the robot's 8-bit response byte from its TX pin; positive ack = 0xA5.
- Self-contained: internal UART TX and RX, one clock domain.

Parameters:
- BAUD_DIV, 2604, clocks per UART bit (50 MHz / 19200 baud); must be >= 16.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- RX  input  1  serial in from robot TX; idle high; asynchronous to clk.
- TX  output  1  serial out to robot RX; idle high.
- cmd  input  16  command word; sampled on send_cmd.
- send_cmd  input  1  single-cycle request to transmit cmd.
- cmd_sent  output  1  high once both bytes are fully sent; held until next accepted send_cmd.
- resp_rdy  output  1  high when a response byte is valid in resp.
- resp  output  8  last received response byte.

Behaviour:
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts BAUD_DIV clocks.
- Reset values: TX=1, cmd_sent=0, resp_rdy=0, resp=0x00; both state machines go to IDLE.
- A reset asserted mid-frame aborts the frame immediately and forces TX=1.
- Command FSM states: IDLE -> SEND_HI -> SEND_LO -> DONE.
  - IDLE: on send_cmd=1, latch cmd, clear cmd_sent, start the high-byte frame (cmd[15:8]); the start bit appears on TX the cycle after send_cmd.
  - SEND_HI: when the high-byte stop bit completes, start the low-byte frame (cmd[7:0]) in the next cycle, with no idle gap.
  - SEND_LO: when the low-byte stop bit completes, set cmd_sent=1 and return to IDLE.
  - Latency from send_cmd to cmd_sent rising = 20*BAUD_DIV + 2 clocks, +/-1.
- send_cmd while not IDLE is ignored; the latched cmd is unchanged and the current transfer continues.
- A change on cmd after the latch has no effect on the transfer.
- cmd_sent is set by completion and cleared only by an accepted send_cmd or by reset.
- TX path:
  - shift register loaded with {stop, data, start}; baud counter counts to BAUD_DIV-1.
  - bit counter 0..9; frame done after the 10th bit period.
- RX path:
  - RX double-flopped (metastability) before use; sync register resets to 1.
  - In IDLE, a falling edge starts the frame.
  - Re-sample at BAUD_DIV/2; if RX is high there, treat it as a false start and return to IDLE.
  - Otherwise sample each data bit at mid-bit, every BAUD_DIV clocks.
  - After the stop-bit sample, load resp and set resp_rdy=1. The stop bit value is not checked.
- resp_rdy is cleared on a valid start bit (the mid-start sample passes), on an accepted send_cmd, or on reset. resp holds its value until overwritten.
- TX and RX operate fully independently and concurrently, full duplex; a response arriving during command transmission is captured normally.
- Back-to-back responses: the second start bit clears resp_rdy, and the new byte sets it again at its stop bit.

Optional Feature:
- Macro: REMOTE_COMM_CHKSUM_EN.
- Defined:
  - after the low byte, add a state SEND_CK that sends a third byte = cmd[15:8] XOR cmd[7:0];
  - cmd_sent rises only after that checksum stop bit, so latency becomes 30*BAUD_DIV + 2 clocks;
  - RX is unchanged.
- Undefined: two-byte transfer exactly as above, and no checksum logic is synthesized.

Test Plan:
- Reset, then idle for 1000 clocks -> TX=1, cmd_sent=0, resp_rdy=0, resp=0x00.
- send_cmd with cmd=0x2000 -> TX decodes as 0x20 then 0x00; cmd_sent rises 20*2604+2 (+/-1) clocks after send_cmd.
- cmd=0x4BF1 sent; a second send_cmd with 0x4002 pulsed mid-high-byte -> bytes are still exactly 0x4B, 0xF1; cmd_sent rises once.
- Drive RX with the byte 0xA5 at 19200 baud -> resp=0xA5 and resp_rdy=1 within one bit time of the stop bit; a following 0x5A frame clears resp_rdy at its start bit, then sets resp=0x5A.
- Pulse RX low for 1000 clocks (< BAUD_DIV/2) -> no reception; resp and resp_rdy unchanged.
- Assert rst during the low byte of cmd=0x57F4 -> TX=1 immediately, cmd_sent=0; a new send_cmd afterwards transfers normally.
- With REMOTE_COMM_CHKSUM_EN, cmd=0x43F3 -> bytes 0x43, 0xF3, 0xB0; cmd_sent rises after the third stop bit.

Source files
------------

// File: rtl/remote_comm.sv
// Knight's Tour bench-side link: sends a 16-bit command as two UART bytes (high first)
// and captures the robot's one-byte response. REMOTE_COMM_CHKSUM_EN appends an XOR checksum byte.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

`ifdef REMOTE_COMM_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, SEND_HI, SEND_LO, SEND_CK, DONE} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO, DONE} tx_state_t;
`endif
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state, tx_next;
    logic [9:0]       tx_shift;
    logic [CNT_W-1:0] tx_baud;
    logic [3:0]       tx_bit;
    logic             tx_active;
    logic             frame_done;
    logic             accept;
    logic             load_frame;
    logic [7:0]       load_byte;
    logic             set_sent;
    logic [7:0]       cmd_lo;
`ifdef REMOTE_COMM_CHKSUM_EN
    logic [7:0]       cmd_hi;
`endif

    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bits;
    logic [7:0]       rx_shift;
    logic             rx_cnt_clr;
    logic             start_ok;
    logic             sample_bit;
    logic             load_resp;

    assign TX = tx_shift[0];
    assign frame_done = tx_active && (tx_baud == BAUD_LAST) && (tx_bit == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_state <= IDLE;
        else
            tx_state <= tx_next;
    end

    // Command sequencer: each frame is loaded the cycle the previous one ends, so bytes are gapless.
    always_comb begin
        tx_next    = tx_state;
        accept     = 1'b0;
        load_frame = 1'b0;
        load_byte  = 8'h00;
        set_sent   = 1'b0;
        case (tx_state)
            IDLE: begin
                if (send_cmd) begin
                    accept     = 1'b1;
                    load_frame = 1'b1;
                    load_byte  = cmd[15:8];
                    tx_next    = SEND_HI;
                end
            end
            SEND_HI: begin
                if (frame_done) begin
                    load_frame = 1'b1;
                    load_byte  = cmd_lo;
                    tx_next    = SEND_LO;
                end
            end
            SEND_LO: begin
                if (frame_done) begin
`ifdef REMOTE_COMM_CHKSUM_EN
                    load_frame = 1'b1;
                    load_byte  = cmd_hi ^ cmd_lo;
                    tx_next    = SEND_CK;
`else
                    tx_next    = DONE;
`endif
                end
            end
`ifdef REMOTE_COMM_CHKSUM_EN
            SEND_CK: begin
                if (frame_done)
                    tx_next = DONE;
            end
`endif
            DONE: begin
                set_sent = 1'b1;
                tx_next  = IDLE;
            end
            default: tx_next = IDLE;
        endcase
    end

    // Shifting in ones keeps the line idle-high once the stop bit has gone out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift  <= '1;
            tx_baud   <= '0;
            tx_bit    <= '0;
            tx_active <= 1'b0;
        end else if (load_frame) begin
            tx_shift  <= {1'b1, load_byte, 1'b0};
            tx_baud   <= '0;
            tx_bit    <= '0;
            tx_active <= 1'b1;
        end else if (tx_active) begin
            if (tx_baud == BAUD_LAST) begin
                tx_baud  <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_bit == 4'd9) begin
                    tx_bit    <= '0;
                    tx_active <= 1'b0;
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_baud <= tx_baud + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_lo   <= 8'h00;
`ifdef REMOTE_COMM_CHKSUM_EN
            cmd_hi   <= 8'h00;
`endif
            cmd_sent <= 1'b0;
        end else begin
            if (accept) begin
                cmd_lo   <= cmd[7:0];
`ifdef REMOTE_COMM_CHKSUM_EN
                cmd_hi   <= cmd[15:8];
`endif
                cmd_sent <= 1'b0;
            end else if (set_sent) begin
                cmd_sent <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rx_state <= RX_IDLE;
        else
            rx_state <= rx_next;
    end

    // Receiver: validate the start bit at its midpoint, then sample every bit period from there.
    always_comb begin
        rx_next    = rx_state;
        rx_cnt_clr = 1'b0;
        start_ok   = 1'b0;
        sample_bit = 1'b0;
        load_resp  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_clr = 1'b1;
                if (rx_prev && !rx_sync)
                    rx_next = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_clr = 1'b1;
                    if (rx_sync) begin
                        rx_next = RX_IDLE;
                    end else begin
                        start_ok = 1'b1;
                        rx_next  = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == BAUD_LAST) begin
                    rx_cnt_clr = 1'b1;
                    sample_bit = 1'b1;
                    if (rx_bits == 3'd7)
                        rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BAUD_LAST) begin
                    rx_cnt_clr = 1'b1;
                    load_resp  = 1'b1;
                    rx_next    = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= 8'h00;
            resp     <= 8'h00;
            resp_rdy <= 1'b0;
        end else begin
            rx_cnt <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
            if (start_ok)
                rx_bits <= '0;
            else if (sample_bit)
                rx_bits <= rx_bits + 3'd1;
            if (sample_bit)
                rx_shift <= {rx_sync, rx_shift[7:1]};
            if (load_resp)
                resp <= rx_shift;
            if (load_resp)
                resp_rdy <= 1'b1;
            else if (start_ok || accept)
                resp_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at a short baud divisor; a UART model on TX collects sent bytes.
// Honours REMOTE_COMM_CHKSUM_EN by expecting the extra checksum byte and longer latency.
module tb_remote_comm;

    localparam int B = 32;
`ifdef REMOTE_COMM_CHKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int LAT = NB * 10 * B + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd = 16'h0000;
    logic        send_cmd = 1'b0;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int sent_rises = 0;
    int rise_cyc = 0;
    int t_send = 0;
    int rises_before = 0;
    logic sent_prev = 1'b0;

    int         mon_cnt = 0;
    logic       mon_busy = 1'b0;
    logic [7:0] mon_sh = 8'h00;
    logic [7:0] tx_bytes[$];

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .TX       (TX),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // UART receiver model on TX: samples mid-bit relative to the detected start edge.
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (TX === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % B == B / 2) begin
                if (mon_cnt / B >= 1 && mon_cnt / B <= 8)
                    mon_sh[mon_cnt / B - 1] = TX;
                else if (mon_cnt / B == 9) begin
                    tx_bytes.push_back(mon_sh);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmd_sent && !sent_prev) begin
            sent_rises++;
            rise_cyc = cyc;
        end
        sent_prev = cmd_sent;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse_send(input logic [15:0] v);
        tx_bytes.delete();
        rises_before = sent_rises;
        @(posedge clk); #1;
        cmd      = v;
        send_cmd = 1'b1;
        @(posedge clk); #1;
        send_cmd = 1'b0;
        t_send   = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sent_rises == rises_before && n < 40 * B) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_transfer(input logic [15:0] v, input string tag);
        logic [7:0] exp_b[3];
        exp_b = '{v[15:8], v[7:0], v[15:8] ^ v[7:0]};
        check_output({tag, ".rises"}, sent_rises, rises_before + 1);
        check_range({tag, ".latency"}, rise_cyc - t_send, LAT - 1, LAT + 1);
        check_output({tag, ".nbytes"}, tx_bytes.size(), NB);
        for (int i = 0; i < NB; i++)
            check_output($sformatf("%s.byte%0d", tag, i),
                         (i < tx_bytes.size()) ? {24'h0, tx_bytes[i]} : 32'hxxxxxxxx, exp_b[i]);
    endtask

    task automatic send_and_check(input logic [15:0] v, input string tag);
        pulse_send(v);
        @(negedge clk);
        check_output({tag, ".sent_clr"}, cmd_sent, 1'b0);
        check_output({tag, ".rdy_clr"}, resp_rdy, 1'b0);
        wait_done();
        check_transfer(v, tag);
        @(negedge clk);
        check_output({tag, ".sent"}, cmd_sent, 1'b1);
        check_output({tag, ".tx_idle"}, TX, 1'b1);
    endtask

    task automatic drive_rx_bits(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(posedge clk);
            #1;
        end
        RX = 1'b1;
        repeat (B) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx_byte(input logic [7:0] b);
        RX = 1'b0;
        repeat (B) @(posedge clk);
        #1;
        drive_rx_bits(b);
    endtask

    initial begin
        $display("[TB] start, BAUD_DIV=%0d, bytes per command=%0d", B, NB);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (1000) @(negedge clk);
        check_output("reset.tx", TX, 1'b1);
        check_output("reset.cmd_sent", cmd_sent, 1'b0);
        check_output("reset.resp_rdy", resp_rdy, 1'b0);
        check_output("reset.resp", resp, 8'h00);

        send_and_check(16'h2000, "c2000");
        repeat (50) @(negedge clk);
        check_output("sent_hold", cmd_sent, 1'b1);

        // Second request mid-high-byte with a new cmd value must be ignored.
        pulse_send(16'h4BF1);
        @(negedge clk);
        check_output("ignore.sent_clr", cmd_sent, 1'b0);
        repeat (5 * B) @(posedge clk);
        #1;
        cmd      = 16'h4002;
        send_cmd = 1'b1;
        @(posedge clk); #1;
        send_cmd = 1'b0;
        wait_done();
        check_transfer(16'h4BF1, "ignore");
        repeat (NB * 10 * B + 4 * B) @(negedge clk);
        check_output("ignore.no_second", sent_rises, rises_before + 1);
        check_output("ignore.no_more_bytes", tx_bytes.size(), NB);

        @(posedge clk); #1;
        drive_rx_byte(8'hA5);
        check_output("rx_a5.resp", resp, 8'hA5);
        check_output("rx_a5.rdy", resp_rdy, 1'b1);
        RX = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        check_output("rx_5a.start_clr", resp_rdy, 1'b0);
        check_output("rx_5a.resp_hold", resp, 8'hA5);
        repeat (B - 24) @(posedge clk);
        #1;
        drive_rx_bits(8'h5A);
        check_output("rx_5a.resp", resp, 8'h5A);
        check_output("rx_5a.rdy", resp_rdy, 1'b1);

        RX = 1'b0;
        repeat (10) @(posedge clk);
        #1 RX = 1'b1;
        repeat (2 * B) @(posedge clk);
        #1;
        check_output("glitch.resp", resp, 8'h5A);
        check_output("glitch.rdy", resp_rdy, 1'b1);

        // Response arriving while a command is going out.
        fork
            send_and_check(16'h1234, "duplex");
            begin
                repeat (3 * B) @(posedge clk);
                #1;
                drive_rx_byte(8'h3C);
            end
        join
        check_output("duplex.resp", resp, 8'h3C);
        check_output("duplex.rdy", resp_rdy, 1'b1);

        pulse_send(16'h57F4);
        repeat (10 * B + B / 2) @(negedge clk);
        check_output("rst.tx_low_start", TX, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_output("rst.tx", TX, 1'b1);
        check_output("rst.cmd_sent", cmd_sent, 1'b0);
        repeat (3) @(negedge clk);
        check_output("rst.resp", resp, 8'h00);
        check_output("rst.rdy", resp_rdy, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check_output("rst.tx_idle", TX, 1'b1);

        send_and_check(16'h1E87, "after_rst");
        send_and_check(16'h43F3, "c43f3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
